// File: rtl/exam_1_alu_pkg.sv
// Shared definitions for the sequential exam_1 ALU: opcodes, FSM encoding
// and the result returned for unsupported select codes.
package exam_1_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;

    localparam int DEFAULT_VAL = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Select codes 3..7 all fall through to the default result.
    function automatic logic is_default_op(input logic [2:0] sel);
        return (sel != OP_ADD) && (sel != OP_AND) && (sel != OP_MUL);
    endfunction

endpackage

// File: rtl/exam_1_mul_seq.sv
// Shift-add unsigned multiplier: always runs exactly WIDTH iterations after
// start, and flags the final iteration so the caller can capture prod.
module exam_1_mul_seq
    import exam_1_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic               busy;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc_next;

    // prod is the accumulator value the current iteration will produce, so
    // the caller can latch the full product on the last iteration edge.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (cnt == LAST);
    assign prod     = acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mcand_in};
            mplier <= mplier_in;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exam_1_alu_seq.sv
// Handshaked ALU responder: ADD/AND/DEFAULT answer one edge after accept,
// MUL goes through the WIDTH-cycle shift-add unit before reaching DONE.
module exam_1_alu_seq
    import exam_1_alu_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_VAL = exam_1_alu_pkg::DEFAULT_VAL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         select,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    state_t             state;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    function automatic logic [2*WIDTH-1:0] fast_result(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [2*WIDTH-1:0] r;
        r = (2*WIDTH)'(DEFAULT_VAL);
        if (!is_default_op(sel)) begin
            if (sel == OP_ADD) begin
                r = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
            end else if (sel == OP_AND) begin
                r = {{WIDTH{1'b1}}, a & b};
            end
        end
        return r;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (select == OP_MUL);

    exam_1_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .mcand_in (X),
        .mplier_in(Y),
        .done     (mul_done),
        .prod     (mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (select == OP_MUL) begin
                            state <= MUL;
                        end else begin
                            out   <= fast_result(select, X, Y);
                            state <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        out   <= mul_prod;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // out stays put after the handshake until the next load.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exam_1_alu_seq.sv
// Directed bench for exam_1_alu_seq with a queue of expected results.
module tb_exam_1_alu_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     select;
    logic [W-1:0]   X;
    logic [W-1:0]   Y;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_res;

    exam_1_alu_seq #(.WIDTH(W), .DEFAULT_VAL(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .select   (select),
        .X        (X),
        .Y        (Y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            3'd0:    return 8'(a) + 8'(b);
            3'd1:    return {4'hF, a & b};
            3'd2:    return 8'(a) * 8'(b);
            default: return 8'd5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one request at a negedge while IDLE; returns #1 after the accept edge.
    task automatic send(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        select   = s;
        X        = a;
        Y        = b;
        in_valid = 1'b1;
        check("in_ready_before_accept", 16'(in_ready), 16'd1);
        exp_q.push_back(model(s, a, b));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen; in_ready must stay low.
    task automatic wait_result(input string tag, input int exp_edges);
        int  edges = 0;
        bit  seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
            check({tag, "_in_ready_busy"}, 16'(in_ready), 16'd0);
            edges++;
        end
        check({tag, "_seen_valid"}, 16'(seen), 16'd1);
        check({tag, "_latency"}, 16'(edges), 16'(exp_edges));
        if (exp_q.size() > 0) begin
            last_res = exp_q.pop_front();
            check({tag, "_out"}, 16'(out), 16'(last_res));
        end
    endtask

    // Consume with out_ready=1 and verify return to IDLE with out held.
    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_low"}, 16'(out_valid), 16'd0);
        check({tag, "_ready_high"}, 16'(in_ready), 16'd1);
        check({tag, "_out_held"}, 16'(out), 16'(last_res));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        select    = '0;
        X         = '0;
        Y         = '0;
        out_ready = 1'b1;
        last_res  = '0;
        #12;
        check("reset_out", 16'(out), 16'd0);
        check("reset_out_valid", 16'(out_valid), 16'd0);
        check("reset_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        rst = 1'b0;

        send(3'd0, 4'd15, 4'd15);
        wait_result("add_15_15", 0);
        consume("add_15_15");

        send(3'd1, 4'd8, 4'd5);
        wait_result("and_8_5", 0);
        consume("and_8_5");

        send(3'd1, 4'd13, 4'd7);
        wait_result("and_13_7", 0);
        consume("and_13_7");

        send(3'd2, 4'd15, 4'd15);
        wait_result("mul_15_15", W);
        consume("mul_15_15");

        send(3'd2, 4'd7, 4'd6);
        wait_result("mul_7_6", W);
        consume("mul_7_6");

        send(3'd2, 4'd0, 4'd8);
        wait_result("mul_0_8", W);
        consume("mul_0_8");

        send(3'd2, 4'd9, 4'd0);
        wait_result("mul_9_0", W);
        consume("mul_9_0");

        for (int s = 3; s < 8; s++) begin
            send(3'(s), 4'd13, 4'd11);
            wait_result($sformatf("default_sel%0d", s), 0);
            consume($sformatf("default_sel%0d", s));
        end

        // Backpressure: result must hold, and a pending request must wait.
        out_ready = 1'b0;
        send(3'd0, 4'd3, 4'd4);
        wait_result("bp_add_3_4", 0);
        @(negedge clk);
        select   = 3'd0;
        X        = 4'd1;
        Y        = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_held", 16'(out_valid), 16'd1);
            check("bp_out_held", 16'(out), 16'(last_res));
            check("bp_not_ready", 16'(in_ready), 16'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_back_idle", 16'(in_ready), 16'd1);
        check("bp_valid_dropped", 16'(out_valid), 16'd0);
        check("bp_out_still_7", 16'(out), 16'(last_res));
        exp_q.push_back(model(3'd0, 4'd1, 4'd1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result("bp_add_1_1", 0);
        consume("bp_add_1_1");

        // Asynchronous reset in the middle of a multiply.
        send(3'd2, 4'd11, 4'd13);
        @(negedge clk);
        @(negedge clk);
        check("mid_mul_busy", 16'(in_ready), 16'd0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out", 16'(out), 16'd0);
        check("async_rst_out_valid", 16'(out_valid), 16'd0);
        check("async_rst_in_ready", 16'(in_ready), 16'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;

        send(3'd2, 4'd5, 4'd3);
        wait_result("mul_after_rst", W);
        consume("mul_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
